game_ctrl: RTL

- Game-state controller for the digit-duel game; the stage directly upstream of the game-page renderer, supplying all of its display inputs.
- Two players each own one row of 5 digits, 10 digits total. Row 0 belongs to player 0, row 1 to player 1.
- A move has two steps: pick one of your own non-zero digits a, then pick a non-zero opponent digit b. Your digit becomes (a+b) mod 10.
- A player whose own row becomes all zero wins.

---
 rtl/game_pkg.sv | 69 ++++++
 rtl/game_ctrl_row_cursor.sv | 43 ++++
 rtl/game_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// game_pkg: definitions shared by the digit-duel game controller.
//   - FSM state encoding (legacy-style localparam constants)
//   - game_end result codes
//   - board geometry (N_DIGITS, DIGIT_W)
//   - digit helpers: modulo-10 add, nibble read/write, row-zero test
package game_pkg;

  localparam int N_DIGITS = 10;
  localparam int DIGIT_W  = 4;

  localparam logic [2:0] ST_SRC   = 3'd0;
  localparam logic [2:0] ST_DST   = 3'd1;
  localparam logic [2:0] ST_APPLY = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_END   = 3'd4;

  localparam logic [1:0] GE_PLAY = 2'd0;
  localparam logic [1:0] GE_P0   = 2'd1;
  localparam logic [1:0] GE_P1   = 2'd2;
  localparam logic [1:0] GE_DRAW = 2'd3;

  // Sum of two decimal digits, wrapped back into 0..9.
  function automatic logic [3:0] digit_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum_s;
    sum_s = {1'b0, a} + {1'b0, b};
    if (sum_s >= 5'd10) begin
      digit_add = 4'(sum_s - 5'd10);
    end else begin
      digit_add = sum_s[3:0];
    end
  endfunction

  // Read digit idx from the packed board; an out-of-range index reads 0.
  function automatic logic [3:0] digit_at(input logic [39:0] d, input logic [3:0] idx);
    case (idx)
      4'd0:    digit_at = d[3:0];
      4'd1:    digit_at = d[7:4];
      4'd2:    digit_at = d[11:8];
      4'd3:    digit_at = d[15:12];
      4'd4:    digit_at = d[19:16];
      4'd5:    digit_at = d[23:20];
      4'd6:    digit_at = d[27:24];
      4'd7:    digit_at = d[31:28];
      4'd8:    digit_at = d[35:32];
      4'd9:    digit_at = d[39:36];
      default: digit_at = 4'd0;
    endcase
  endfunction

  // Return the board with digit idx replaced by v.
  function automatic logic [39:0] digit_set(input logic [39:0] d, input logic [3:0] idx,
                                            input logic [3:0] v);
    logic [39:0] r;
    r = d;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == 4'(k)) begin
        r[4*k +: 4] = v;
      end else begin
        r[4*k +: 4] = d[4*k +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic row_zero(input logic [19:0] row);
    row_zero = (row == 20'd0);
  endfunction

endpackage

// File: rtl/game_ctrl_row_cursor.sv
// row_cursor: board cursor made of a row bit and a wrapping 0..4 offset.
//   vga_clk, vga_rst : pixel clock, synchronous active-high reset
//   srst             : synchronous clear (new game), same effect as reset
//   step_left/right  : move offset -1/+1 with wrap; both together do nothing
//   load, load_row, load_off : jump straight to a row/offset (wins over steps)
//   idx              : absolute digit index, row*5 + offset
module row_cursor
  import game_pkg::*;
(
  input  logic       vga_clk,
  input  logic       vga_rst,
  input  logic       srst,
  input  logic       step_left,
  input  logic       step_right,
  input  logic       load,
  input  logic       load_row,
  input  logic [2:0] load_off,
  output logic [3:0] idx
);

  logic       row_r;
  logic [2:0] off_r;

  // Cursor position register: clear, jump, or wrap-step inside the row.
  always_ff @(posedge vga_clk) begin
    if (vga_rst || srst) begin
      row_r <= 1'b0;
      off_r <= 3'd0;
    end else if (load) begin
      row_r <= load_row;
      off_r <= load_off;
    end else if (step_right && !step_left) begin
      off_r <= (off_r == 3'd4) ? 3'd0 : off_r + 3'd1;
    end else if (step_left && !step_right) begin
      off_r <= (off_r == 3'd0) ? 3'd4 : off_r - 3'd1;
    end else begin
      off_r <= off_r;
    end
  end

  assign idx = row_r ? (4'd5 + {1'b0, off_r}) : {1'b0, off_r};

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: game-state controller for the digit-duel game; feeds every
// display input of the game-page renderer.
//   vga_clk, vga_rst         : pixel clock, synchronous active-high reset
//   btn_left/right/ok/back/start : one-cycle debounced button pulses
//   total_number             : digits per row (constant)
//   cur_player               : player to move
//   status                   : 10 packed digits, digit k at [4k+3:4k]
//   cur_select, selected     : cursor / held source index, times 4
//   selecting                : a source digit is held
//   predict, predict_valid   : result digit for the destination under the cursor
//   game_end                 : GE_PLAY / GE_P0 / GE_P1 / GE_DRAW
// Optional build macro GAME_MOVE_LIMIT_EN adds a move counter; reaching
// MAX_MOVES without a winner ends the game as a draw.
module game_ctrl
  import game_pkg::*;
#(
  parameter int N_PER_ROW  = 5,
  parameter int INIT_DIGIT = 1
`ifdef GAME_MOVE_LIMIT_EN
  ,
  parameter int MAX_MOVES  = 64
`endif
) (
  input  logic        vga_clk,
  input  logic        vga_rst,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_ok,
  input  logic        btn_back,
  input  logic        btn_start,
  output logic [31:0] total_number,
  output logic        cur_player,
  output logic [39:0] status,
  output logic [31:0] cur_select,
  output logic [31:0] selected,
  output logic        selecting,
  output logic [3:0]  predict,
  output logic        predict_valid,
  output logic [1:0]  game_end
);

  localparam logic [3:0]  INIT_NIB   = 4'(INIT_DIGIT);
  localparam logic [39:0] INIT_BOARD = {N_DIGITS{INIT_NIB}};

  logic [2:0]  state_r;
  logic [39:0] digits_r;
  logic        cur_player_r;
  logic        selecting_r;
  logic [3:0]  sel_idx_r;
  logic [1:0]  game_end_r;

  logic [3:0]  cur_idx_s;
  logic [3:0]  cur_digit_s;
  logic [3:0]  sel_digit_s;
  logic [3:0]  sum_s;
  logic        legal_dst_s;
  logic        own_zero_s;
  logic        limit_hit_s;
  logic [2:0]  sel_off_s;

  logic        act_start_s;
  logic        act_back_s;
  logic        act_ok_s;
  logic        act_lr_s;

  logic        cur_left_s;
  logic        cur_right_s;
  logic        cur_load_s;
  logic        cur_load_row_s;
  logic [2:0]  cur_load_off_s;

`ifdef GAME_MOVE_LIMIT_EN
  localparam int MC_W = $clog2(MAX_MOVES + 1);
  logic [MC_W-1:0] move_cnt_r;
  assign limit_hit_s = (move_cnt_r >= MC_W'(MAX_MOVES));
`else
  assign limit_hit_s = 1'b0;
`endif

  // Button priority: only the highest-priority pressed button acts.
  always_comb begin
    act_start_s = btn_start;
    act_back_s  = !btn_start && btn_back;
    act_ok_s    = !btn_start && !btn_back && btn_ok;
    act_lr_s    = !btn_start && !btn_back && !btn_ok;
  end

  // Datapath: digits under cursor/selection, their sum, and move legality.
  always_comb begin
    cur_digit_s = digit_at(digits_r, cur_idx_s);
    sel_digit_s = digit_at(digits_r, sel_idx_r);
    sum_s       = digit_add(sel_digit_s, cur_digit_s);
    legal_dst_s = (state_r == ST_DST) && (cur_digit_s != 4'd0);
    if (cur_player_r) begin
      own_zero_s = row_zero(digits_r[39:20]);
      sel_off_s  = 3'(sel_idx_r - 4'd5);
    end else begin
      own_zero_s = row_zero(digits_r[19:0]);
      sel_off_s  = sel_idx_r[2:0];
    end
  end

  // Cursor commands: steps in SRC/DST, jumps on pick, back and turn change.
  always_comb begin
    cur_left_s     = 1'b0;
    cur_right_s    = 1'b0;
    cur_load_s     = 1'b0;
    cur_load_row_s = 1'b0;
    cur_load_off_s = 3'd0;
    case (state_r)
      ST_SRC: begin
        if (act_ok_s && (cur_digit_s != 4'd0)) begin
          cur_load_s     = 1'b1;
          cur_load_row_s = ~cur_player_r;
        end else if (act_lr_s) begin
          cur_left_s  = btn_left;
          cur_right_s = btn_right;
        end else begin
          cur_load_s = 1'b0;
        end
      end
      ST_DST: begin
        if (act_back_s) begin
          cur_load_s     = 1'b1;
          cur_load_row_s = cur_player_r;
          cur_load_off_s = sel_off_s;
        end else if (act_lr_s) begin
          cur_left_s  = btn_left;
          cur_right_s = btn_right;
        end else begin
          cur_load_s = 1'b0;
        end
      end
      ST_CHECK: begin
        if (!own_zero_s && !limit_hit_s) begin
          cur_load_s     = 1'b1;
          cur_load_row_s = ~cur_player_r;
        end else begin
          cur_load_s = 1'b0;
        end
      end
      default: begin
        cur_load_s = 1'b0;
      end
    endcase
  end

  row_cursor u_cursor (
    .vga_clk    (vga_clk),
    .vga_rst    (vga_rst),
    .srst       (act_start_s),
    .step_left  (cur_left_s),
    .step_right (cur_right_s),
    .load       (cur_load_s),
    .load_row   (cur_load_row_s),
    .load_off   (cur_load_off_s),
    .idx        (cur_idx_s)
  );

  // Game FSM and board state; start behaves exactly like reset.
  always_ff @(posedge vga_clk) begin
    if (vga_rst || act_start_s) begin
      state_r      <= ST_SRC;
      digits_r     <= INIT_BOARD;
      cur_player_r <= 1'b0;
      selecting_r  <= 1'b0;
      sel_idx_r    <= 4'd0;
      game_end_r   <= GE_PLAY;
`ifdef GAME_MOVE_LIMIT_EN
      move_cnt_r   <= '0;
`endif
    end else begin
      case (state_r)
        ST_SRC: begin
          if (act_ok_s && (cur_digit_s != 4'd0)) begin
            sel_idx_r   <= cur_idx_s;
            selecting_r <= 1'b1;
            state_r     <= ST_DST;
          end
        end
        ST_DST: begin
          if (act_back_s) begin
            selecting_r <= 1'b0;
            state_r     <= ST_SRC;
          end else if (act_ok_s && legal_dst_s) begin
            state_r <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          digits_r    <= digit_set(digits_r, sel_idx_r, sum_s);
          selecting_r <= 1'b0;
`ifdef GAME_MOVE_LIMIT_EN
          move_cnt_r  <= move_cnt_r + 1'b1;
`endif
          state_r     <= ST_CHECK;
        end
        ST_CHECK: begin
          // Only the mover's digits changed, so only the mover can have won.
          if (own_zero_s) begin
            game_end_r <= cur_player_r ? GE_P1 : GE_P0;
            state_r    <= ST_END;
          end else if (limit_hit_s) begin
            game_end_r <= GE_DRAW;
            state_r    <= ST_END;
          end else begin
            cur_player_r <= ~cur_player_r;
            state_r      <= ST_SRC;
          end
        end
        ST_END: begin
          state_r <= ST_END;
        end
        default: begin
          state_r <= ST_SRC;
        end
      endcase
    end
  end

  assign total_number  = 32'(N_PER_ROW);
  assign cur_player    = cur_player_r;
  assign status        = digits_r;
  assign cur_select    = {26'd0, cur_idx_s, 2'b00};
  assign selected      = {26'd0, sel_idx_r, 2'b00};
  assign selecting     = selecting_r;
  assign predict       = legal_dst_s ? sum_s : 4'hF;
  assign predict_valid = legal_dst_s;
  assign game_end      = game_end_r;

endmodule
